// File: rtl/ex_divide_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_divide_unit
// Purpose  : Multi-cycle restoring integer divider (signed/unsigned) with
//            valid/ready handshakes, flush and defined divide-by-zero result.
// Revision : 1.0
// ============================================================================
module ex_divide_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter bit ZERO_EARLY_OUT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             request_valid,
    output logic             request_ready,
    input  logic             request_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divide_by_zero,
    output logic             busy
);

    localparam int                 c_ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int                 c_CNT_W = $clog2(c_ITERS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_ITERS - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ITERATE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_early_out;
    logic               w_dvd_neg;
    logic               w_dsr_neg;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dsr_mag;
    logic               w_last;

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dsr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_zero;

    logic [WIDTH:0]     w_sh;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    assign request_ready = ~flush & ((r_state == S_IDLE) |
                                     ((r_state == S_DONE) & result_ready));
    assign w_accept      = request_valid & request_ready;
    assign w_div_zero    = (divisor == '0);
    assign w_early_out   = ZERO_EARLY_OUT & w_div_zero;
    assign w_dvd_neg     = request_signed & dividend[WIDTH-1];
    assign w_dsr_neg     = request_signed & divisor[WIDTH-1];
    assign w_dvd_mag     = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dsr_mag     = w_dsr_neg ? (~divisor + 1'b1) : divisor;
    assign w_last        = (r_cnt == c_LAST);

    // The shifted partial remainder is always below 2*divisor (or below 2^WIDTH
    // for a zero divisor), so bit WIDTH of the difference is the borrow.
    always_comb begin
        w_rem_next = r_rem;
        w_quo_next = r_quo;
        w_sh       = '0;
        w_diff     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_sh   = {w_rem_next, w_quo_next[WIDTH-1]};
            w_diff = w_sh - {1'b0, r_dsr};
            if (!w_diff[WIDTH]) begin
                w_rem_next = w_diff[WIDTH-1:0];
                w_quo_next = {w_quo_next[WIDTH-2:0], 1'b1};
            end else begin
                w_rem_next = w_sh[WIDTH-1:0];
                w_quo_next = {w_quo_next[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign w_quo_fix = r_zero  ? '1 :
                       r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_rem_fix = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_next = w_early_out ? S_DONE : S_ITERATE;
                end else if ((r_state == S_DONE) && result_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            S_ITERATE: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_dsr       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_zero      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_rem   <= '0;
            r_quo   <= w_dvd_mag;
            r_dsr   <= w_dsr_mag;
            r_cnt   <= '0;
            r_neg_q <= w_dvd_neg ^ w_dsr_neg;
            r_neg_r <= w_dvd_neg;
            r_zero  <= w_div_zero;
            if (w_early_out) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
                r_dbz       <= 1'b1;
            end
        end else if (r_state == S_ITERATE) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + c_ONE;
            if (w_last) begin
                r_quotient  <= w_quo_fix;
                r_remainder <= w_rem_fix;
                r_dbz       <= r_zero;
            end
        end
    end

    assign result_valid   = (r_state == S_DONE);
    assign busy           = (r_state != S_IDLE);
    assign quotient       = r_quotient;
    assign remainder      = r_remainder;
    assign divide_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_ex_divide_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_divide_unit
// Purpose  : Directed self-checking bench for ex_divide_unit (three configs).
// Revision : 1.0
// ============================================================================
module tb_ex_divide_unit;

    typedef struct {
        int          sel;
        logic        sg;
        logic [31:0] dd;
        logic [31:0] ds;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [2:0]  rv;
    logic        req_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        result_ready;

    logic        a_rdy, a_val, a_dbz, a_busy;
    logic [31:0] a_q, a_r;
    logic        b_rdy, b_val, b_dbz, b_busy;
    logic [31:0] b_q, b_r;
    logic        c_rdy, c_val, c_dbz, c_busy;
    logic [15:0] c_q, c_r;

    int          sel;
    logic        cur_rdy, cur_val, cur_dbz, cur_busy;
    logic [31:0] cur_q, cur_r;

    int          checks;
    int          errors;

    ex_divide_unit #(.WIDTH(32), .BITS_PER_CYCLE(1), .ZERO_EARLY_OUT(1'b1)) u_a (
        .clock(clock), .reset(reset), .request_valid(rv[0]), .request_ready(a_rdy),
        .request_signed(req_signed), .dividend(dividend), .divisor(divisor),
        .flush(flush), .result_valid(a_val), .result_ready(result_ready),
        .quotient(a_q), .remainder(a_r), .divide_by_zero(a_dbz), .busy(a_busy)
    );

    ex_divide_unit #(.WIDTH(32), .BITS_PER_CYCLE(1), .ZERO_EARLY_OUT(1'b0)) u_b (
        .clock(clock), .reset(reset), .request_valid(rv[1]), .request_ready(b_rdy),
        .request_signed(req_signed), .dividend(dividend), .divisor(divisor),
        .flush(flush), .result_valid(b_val), .result_ready(result_ready),
        .quotient(b_q), .remainder(b_r), .divide_by_zero(b_dbz), .busy(b_busy)
    );

    ex_divide_unit #(.WIDTH(16), .BITS_PER_CYCLE(2), .ZERO_EARLY_OUT(1'b1)) u_c (
        .clock(clock), .reset(reset), .request_valid(rv[2]), .request_ready(c_rdy),
        .request_signed(req_signed), .dividend(dividend[15:0]), .divisor(divisor[15:0]),
        .flush(flush), .result_valid(c_val), .result_ready(result_ready),
        .quotient(c_q), .remainder(c_r), .divide_by_zero(c_dbz), .busy(c_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        cur_rdy  = a_rdy;
        cur_val  = a_val;
        cur_dbz  = a_dbz;
        cur_busy = a_busy;
        cur_q    = a_q;
        cur_r    = a_r;
        if (sel == 1) begin
            cur_rdy = b_rdy; cur_val = b_val; cur_dbz = b_dbz; cur_busy = b_busy;
            cur_q   = b_q;   cur_r   = b_r;
        end else if (sel == 2) begin
            cur_rdy = c_rdy; cur_val = c_val; cur_dbz = c_dbz; cur_busy = c_busy;
            cur_q   = {16'h0, c_q}; cur_r = {16'h0, c_r};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int s, input logic sg, input logic [31:0] dd,
                                input logic [31:0] ds, input logic [31:0] q,
                                input logic [31:0] r, input logic z, input int lat);
        vec_t v;
        v.sel = s; v.sg = sg; v.dd = dd; v.ds = ds;
        v.q = q; v.r = r; v.z = z; v.lat = lat;
        return v;
    endfunction

    // Waits (bounded) for the selected unit's result; returns posedges counted from the accept edge.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!cur_val && lat < 100) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int lat;
        sel = v.sel;
        @(negedge clock);
        chk({nm, " req_ready"}, {31'b0, cur_rdy}, 32'd1);
        req_signed   = v.sg;
        dividend     = v.dd;
        divisor      = v.ds;
        result_ready = 1'b0;
        rv[v.sel]    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rv = '0;
        wait_result(lat);
        chk({nm, " latency"}, 32'(lat), 32'(v.lat));
        chk({nm, " quotient"}, cur_q, v.q);
        chk({nm, " remainder"}, cur_r, v.r);
        chk({nm, " dbz"}, {31'b0, cur_dbz}, {31'b0, v.z});
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
        chk({nm, " valid_drop"}, {31'b0, cur_val}, 32'd0);
    endtask

    initial begin
        vec_t        tbl[$];
        int          lat;
        logic        seen;
        logic [31:0] hq, hr;
        logic [15:0] d16, s16;
        logic        sg;
        longint      sa, sb, qq, rr;
        vec_t        v;

        checks = 0; errors = 0; sel = 0;
        reset = 1'b1; rv = '0; req_signed = 1'b0; dividend = '0; divisor = '0;
        flush = 1'b0; result_ready = 1'b0;

        // Width-32 radix-2 unit with early out
        tbl.push_back(mk(0, 0, 32'd100,       32'd7,         32'd14,        32'd2,         0, 33));
        tbl.push_back(mk(0, 1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  0, 33));
        tbl.push_back(mk(0, 1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         0, 33));
        tbl.push_back(mk(0, 1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         0, 33));
        tbl.push_back(mk(0, 0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         0, 33));
        tbl.push_back(mk(0, 0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  0, 33));
        tbl.push_back(mk(0, 1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  0, 33));
        tbl.push_back(mk(0, 0, 32'd3,         32'd10,        32'd0,         32'd3,         0, 33));
        tbl.push_back(mk(0, 1, 32'h80000000,  32'd2,         32'hC0000000,  32'd0,         0, 33));
        tbl.push_back(mk(0, 0, 32'hFFFFFFFE,  32'h00010000,  32'h0000FFFF,  32'h0000FFFE,  0, 33));
        tbl.push_back(mk(0, 1, 32'h7FFFFFFF,  32'hFFFFFFFF,  32'h80000001,  32'd0,         0, 33));
        tbl.push_back(mk(0, 0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1, 1));
        tbl.push_back(mk(0, 1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1, 1));
        // Width-32 unit without early out
        tbl.push_back(mk(1, 0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1, 33));
        tbl.push_back(mk(1, 1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1, 33));
        // Width-16 radix-4 unit
        tbl.push_back(mk(2, 0, 32'd1000,      32'd7,         32'd142,       32'd6,         0, 9));
        tbl.push_back(mk(2, 1, 32'hFF9C,      32'd7,         32'hFFF2,      32'hFFFE,      0, 9));
        tbl.push_back(mk(2, 1, 32'h8000,      32'hFFFF,      32'h8000,      32'd0,         0, 9));
        tbl.push_back(mk(2, 0, 32'hFFFF,      32'h00FF,      32'h0101,      32'd0,         0, 9));
        tbl.push_back(mk(2, 1, 32'h7FFF,      32'hFFFE,      32'hC001,      32'd1,         0, 9));
        tbl.push_back(mk(2, 0, 32'h1234,      32'd0,         32'hFFFF,      32'h1234,      1, 1));
        tbl.push_back(mk(2, 1, 32'h8000,      32'd0,         32'hFFFF,      32'h8000,      1, 1));

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst valid", {31'b0, a_val}, 32'd0);
        chk("rst quotient", a_q, 32'd0);
        chk("rst remainder", a_r, 32'd0);
        chk("rst dbz", {31'b0, a_dbz}, 32'd0);
        chk("rst busy", {31'b0, a_busy}, 32'd0);
        chk("rst req_ready", {31'b0, a_rdy}, 32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure, then back-to-back accept while releasing the result
        sel = 0;
        @(negedge clock);
        req_signed = 1'b0; dividend = 32'd20; divisor = 32'd6; rv = 3'b001;
        @(posedge clock);
        @(negedge clock);
        rv = '0;
        wait_result(lat);
        chk("bp latency", 32'(lat), 32'd33);
        hq = 32'd3; hr = 32'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("bp hold q %0d", i), a_q, hq);
            chk($sformatf("bp hold r %0d", i), a_r, hr);
            chk($sformatf("bp hold valid %0d", i), {31'b0, a_val}, 32'd1);
            chk($sformatf("bp req_ready %0d", i), {31'b0, a_rdy}, 32'd0);
        end
        dividend = 32'd9; divisor = 32'd3; rv = 3'b001; result_ready = 1'b1;
        #1;
        chk("b2b req_ready", {31'b0, a_rdy}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        rv = '0; result_ready = 1'b0;
        chk("b2b valid_drop", {31'b0, a_val}, 32'd0);
        chk("b2b busy", {31'b0, a_busy}, 32'd1);
        wait_result(lat);
        chk("b2b latency", 32'(lat), 32'd33);
        chk("b2b quotient", a_q, 32'd3);
        chk("b2b remainder", a_r, 32'd0);
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;

        // Flush at iteration cycle 10, with a competing request that must be refused
        @(negedge clock);
        dividend = 32'd100; divisor = 32'd7; rv = 3'b001;
        @(posedge clock);
        @(negedge clock);
        rv = '0;
        repeat (9) @(negedge clock);
        flush = 1'b1; rv = 3'b001;
        #1;
        chk("flush req_ready", {31'b0, a_rdy}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        flush = 1'b0; rv = '0;
        chk("flush busy", {31'b0, a_busy}, 32'd0);
        chk("flush valid", {31'b0, a_val}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen = seen | a_val | a_busy;
        end
        chk("flush no result", {31'b0, seen}, 32'd0);

        // Asynchronous reset between edges while iterating
        @(negedge clock);
        dividend = 32'd100; divisor = 32'd7; rv = 3'b001;
        @(posedge clock);
        @(negedge clock);
        rv = '0;
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("areset busy", {31'b0, a_busy}, 32'd0);
        chk("areset valid", {31'b0, a_val}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen = seen | a_val;
        end
        chk("areset no result", {31'b0, seen}, 32'd0);

        // Width-16 radix-4 unit against a plain integer reference
        for (int i = 0; i < 24; i++) begin
            d16 = 16'($urandom);
            s16 = (i % 6 == 0) ? 16'h0 : 16'($urandom);
            sg  = 1'($urandom);
            if (i % 7 == 3) begin
                d16 = 16'h8000; s16 = 16'hFFFF; sg = 1'b1;
            end
            sa = sg ? longint'($signed(d16)) : longint'(d16);
            sb = sg ? longint'($signed(s16)) : longint'(s16);
            if (s16 == 16'h0) begin
                v = mk(2, sg, {16'h0, d16}, 32'd0, 32'h0000FFFF, {16'h0, d16}, 1, 1);
            end else begin
                qq = sa / sb;
                rr = sa % sb;
                v = mk(2, sg, {16'h0, d16}, {16'h0, s16},
                       {16'h0, qq[15:0]}, {16'h0, rr[15:0]}, 0, 9);
            end
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
